// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared constants and types for the accumulator sequencer
// Purpose: data width, opcode encodings, FSM state encoding and an opcode
//          legality helper shared by acc_seq and acc_seq_flags.
// Ports:   none (package).
package acc_pkg;

  localparam int DW = 4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_LOAD = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Everything above LOAD is reserved and executes as a NOP.
  function automatic logic is_illegal(input logic [3:0] op);
    return op > OP_LOAD;
  endfunction

endpackage

// File: rtl/acc_seq_flags.sv
// rtl/acc_seq_flags.sv - combinational status flag computation
// Purpose: zero/neg from the accumulator and, with ACC_SEQ_OVF_EN defined,
//          per-iteration signed overflow detection for ADD/SUB.
// Ports:   acc     in  DW  current accumulator (ALU A)
//          zero    out 1   acc == 0
//          neg     out 1   acc sign bit
//          opnd    in  DW  latched operand (ALU B)        [ACC_SEQ_OVF_EN]
//          alu_out in  DW  ALU result                     [ACC_SEQ_OVF_EN]
//          op      in  4   latched opcode                 [ACC_SEQ_OVF_EN]
//          ovf_hit out 1   this iteration overflows       [ACC_SEQ_OVF_EN]
module acc_seq_flags
  import acc_pkg::*;
(
  input  logic [DW-1:0] acc,
  output logic          zero,
  output logic          neg
`ifdef ACC_SEQ_OVF_EN
  ,
  input  logic [DW-1:0] opnd,
  input  logic [DW-1:0] alu_out,
  input  logic [3:0]    op,
  output logic          ovf_hit
`endif
);

  assign zero = (acc == '0);
  assign neg  = acc[DW-1];

`ifdef ACC_SEQ_OVF_EN
  // For SUB the effective operand is -B, whose sign is the inverse of B's.
  // The one exception is B = -8 (no positive counterpart): there the test
  // reduces to "A non-negative", which is exactly when A - (-8) overflows.
  // B = 0 cannot false-trigger because A - 0 never changes sign.
  always_comb begin
    ovf_hit = 1'b0;
    if (op == OP_ADD)
      ovf_hit = (acc[DW-1] == opnd[DW-1]) && (alu_out[DW-1] != acc[DW-1]);
    else if (op == OP_SUB)
      ovf_hit = (acc[DW-1] != opnd[DW-1]) && (alu_out[DW-1] != acc[DW-1]);
  end
`endif

endmodule

// File: rtl/acc_seq.sv
// rtl/acc_seq.sv - instruction sequencer for the 4-bit signed accumulator
// Purpose: accepts one instruction (op, operand, repeat) per handshake, drives
//          an external ALU with A = acc and B = latched operand, writes the
//          result back once per iteration and reports retirement flags.
//          Optional overflow reporting is built with ACC_SEQ_OVF_EN.
// Ports:   clk, rst (async, active high)
//          in_valid/in_ready handshake, in_op[4], in_operand[4], in_rep[2]
//          alu_a/alu_b/alu_op out to the ALU, alu_out back from it
//          acc[4], done (retire pulse), err, zero, neg, ovf [ACC_SEQ_OVF_EN]
module acc_seq
  import acc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [DW-1:0] in_operand,
  input  logic [1:0]    in_rep,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_op,
  input  logic [DW-1:0] alu_out,
  output logic [DW-1:0] acc,
  output logic          done,
  output logic          err,
  output logic          zero,
  output logic          neg
`ifdef ACC_SEQ_OVF_EN
  ,
  output logic          ovf
`endif
);

  state_t        state, state_nx;
  logic [3:0]    op_q;
  logic [DW-1:0] opnd_q;
  logic [1:0]    cnt;
  logic          zero_c, neg_c;

  assign alu_a  = acc;
  assign alu_b  = opnd_q;
  assign alu_op = op_q;

`ifdef ACC_SEQ_OVF_EN
  logic ovf_hit, ovf_q;

  acc_seq_flags u_flags (
    .acc     (acc),
    .zero    (zero_c),
    .neg     (neg_c),
    .opnd    (opnd_q),
    .alu_out (alu_out),
    .op      (op_q),
    .ovf_hit (ovf_hit)
  );
`else
  acc_seq_flags u_flags (
    .acc  (acc),
    .zero (zero_c),
    .neg  (neg_c)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ST_EXEC;
      end
      ST_EXEC: if (cnt == 2'd0) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Flags are captured on the edge that leaves DONE, so done/err/zero/neg
  // become visible together in the first IDLE cycle after retirement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      opnd_q <= '0;
      cnt    <= '0;
      acc    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      zero   <= 1'b1;
      neg    <= 1'b0;
`ifdef ACC_SEQ_OVF_EN
      ovf_q  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q   <= in_op;
            opnd_q <= in_operand;
            cnt    <= in_rep;
`ifdef ACC_SEQ_OVF_EN
            ovf_q  <= 1'b0;
`endif
          end
        end
        ST_EXEC: begin
          if (op_q == OP_LOAD)
            acc <= opnd_q;
          else if (!is_illegal(op_q))
            acc <= alu_out;
          if (cnt != 2'd0) cnt <= cnt - 2'd1;
`ifdef ACC_SEQ_OVF_EN
          ovf_q <= ovf_q | ovf_hit;
`endif
        end
        ST_DONE: begin
          done <= 1'b1;
          zero <= zero_c;
          neg  <= neg_c;
          err  <= is_illegal(op_q);
`ifdef ACC_SEQ_OVF_EN
          ovf  <= ovf_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/acc_seq.md
# acc_seq

Sequencer for the 4-bit signed accumulator datapath. It accepts one instruction at a time (opcode, operand, repeat count) over a valid/ready handshake and drives the external 4-bit signed ALU with A = accumulator and B = latched operand. It writes the ALU result back into the accumulator once per iteration and reports completion with status flags. It sits between the instruction source (test driver or future program ROM) and the ALU.

## Interface
- No parameters; data width is fixed at 4 bits (package constant).
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: instruction present.
- `in_ready` out 1: block can accept an instruction.
- `in_op` in 4: opcode.
- `in_operand` in 4: signed operand.
- `in_rep` in 2: the instruction executes `in_rep`+1 times.
- `alu_a` out 4: ALU A input; always the accumulator.
- `alu_b` out 4: ALU B input; the latched operand.
- `alu_op` out 4: ALU opcode; the latched opcode.
- `alu_out` in 4: ALU result; combinational from `alu_a`/`alu_b`/`alu_op`.
- `acc` out 4: signed accumulator value.
- `done` out 1: one-cycle pulse when an instruction retires.
- `err` out 1: valid with `done`; the opcode was illegal.
- `zero` out 1: `acc` == 0, registered at retire.
- `neg` out 1: `acc`[3], registered at retire.
- `ovf` out 1: signed overflow seen during the instruction. Present only with `ACC_SEQ_OVF_EN`.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(B), 6 SHL, 7 SHR: executed by the ALU.
  - 8 LOAD: acc <= operand. Handled internally; the ALU result is ignored.
  - 9–15: illegal. Treated as NOP, acc unchanged, `err`=1 at retire.
- FSM states and transitions:
  - IDLE: `in_ready`=1. On `in_valid`, latch op, operand and rep into `op_q`/`opnd_q`/`cnt`, then go to EXEC.
  - EXEC: `in_ready`=0. Every cycle, acc <= `alu_out` (or operand for LOAD, or hold for illegal). If `cnt`==0, go to DONE; otherwise decrement `cnt` and stay in EXEC.
  - DONE: `done`=1 for one cycle. `zero`, `neg` and `err` update. Return to IDLE.
- Repeats feed back through the accumulator. Example: SHL with rep=2 shifts acc left three times.
- For LOAD and illegal opcodes, repeats simply re-apply the same action.
- `in_valid` while not in IDLE is ignored. The source must hold `in_valid` until it sees `in_ready`.
- `alu_a`, `alu_b` and `alu_op` are driven from registers in every state. Outside EXEC, `alu_out` is ignored.
- Arithmetic is 4-bit two's-complement, wrap-around, with no saturation.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `acc`=0, `alu_a`=0, `alu_b`=0, `alu_op`=0, `done`=0, `err`=0, `zero`=1, `neg`=0, `ovf`=0.
- Accept edge to `done` pulse: rep+2 cycles (rep+1 EXEC cycles plus 1 DONE cycle).
- Minimum spacing between instructions: rep+3 cycles, because the block returns to IDLE for at least one cycle before the next accept.
- `acc` updates at the end of each EXEC cycle. It is stable in DONE and IDLE.
- Reset asserted mid-instruction aborts it immediately. No `done` pulse is produced, and all outputs take their reset values.

## Configuration
- `ACC_SEQ_OVF_EN` defined:
  - `ovf` port and a sticky overflow register exist.
  - The register clears on accept.
  - It sets in any EXEC cycle of ADD/SUB where the signs of A and the effective B match and `alu_out`'s sign differs. Effective B is B for ADD and −B for SUB.
  - SUB with B = −8 counts as overflow whenever A ≥ 0.
  - `ovf` is registered at retire together with the other flags.
- `ACC_SEQ_OVF_EN` undefined: no `ovf` port and no overflow logic; all other behaviour is identical.

## Structure
- Shared package `acc_pkg`: data width constant (4), opcode localparams (OP_ADD … OP_LOAD), FSM state encoding (IDLE/EXEC/DONE).
- One sub-module, `acc_seq_flags`: combinational zero/neg/ovf computation from acc, operand, `alu_out` and op.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- Reset, then LOAD 5 rep 0 → `done` 2 cycles after accept; acc=5, zero=0, neg=0, err=0.
- With acc=5: ADD 3 rep 0 → acc=−8, neg=1, ovf=1 (with macro); `ovf` port absent when built without the macro.
- LOAD 1, then SHL rep 2 → three EXEC cycles, acc=8 (i.e. −8), `done` 4 cycles after accept.
- Opcode 12 with acc=−3 → acc stays −3, err=1 with `done`; the next instruction has err=0.
- SUB 3 from acc=3 → acc=0, zero=1; `in_valid` pulsed during EXEC is ignored, `in_ready`=0 until IDLE.
- ADD 1 rep 3 issued, then `rst` asserted in the second EXEC cycle → acc=0 immediately, no `done` pulse, `in_ready`=1 after release.
